grf_wb_unit: RTL and testbench
==============================

Name: grf_wb_unit

Overview:
- Write-side front end of the general register file in the multi-cycle CPU.
- Accepts one writeback request per instruction from the main control FSM and selects the result source: ALU, memory load, link address or LUI immediate.
- For loads, waits for memory data, then extracts and extends the addressed byte or halfword.
- Drives the register file write port (Waddr/regwrite/Wdata) for exactly one cycle per request and reports completion.

Parameters:
- LINK_OFFSET, 8, added to req_pc for link writes (jal/jalr return address).
- LINK_REG, 31, destination register forced when req_src=LINK and req_link_ra=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  writeback request present.
- req_ready  out  1  unit can accept a request (IDLE state).
- req_waddr  in  5  destination register number.
- req_src  in  2  result source: 00 ALU, 01 MEM, 10 LINK, 11 LUI.
- req_link_ra  in  1  for LINK, override destination with LINK_REG.
- req_alu  in  32  ALU result.
- req_pc  in  32  PC of the instruction.
- req_imm  in  16  immediate field.
- req_ldtype  in  3  load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others are illegal.
- req_addr_lo  in  2  effective address bits [1:0].
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  32  load data word.
- Waddr  out  5  register file write address.
- regwrite  out  1  register file write enable.
- Wdata  out  32  register file write data.
- done  out  1  one-cycle pulse when a request retires.
- align_err  out  1  one-cycle pulse for a misaligned or illegal load; no write occurs.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE, Waddr=0, Wdata=0, regwrite=0, done=0, align_err=0, busy=0.
  - All captured request fields are cleared.
- Reset asserted mid-operation abandons the request; no write and no done.
- States are IDLE, WAIT_MEM, WRITE.
- IDLE:
  - req_ready=1.
  - A handshake occurs when req_valid=1 in IDLE; all req_* fields are captured at that edge.
  - src ALU, LINK or LUI goes to WRITE. The result is computed at capture:
    - ALU: the result is req_alu.
    - LINK: the result is req_pc+LINK_OFFSET (mod 2^32).
    - LUI: the result is {req_imm,16'h0}.
  - src MEM goes to WAIT_MEM.
- WAIT_MEM:
  - Holds until mem_rvalid=1 and ignores req_valid.
  - On mem_rvalid, the aligned result is latched and the state goes to WRITE. If the load is misaligned or illegal, the state returns to IDLE with an align_err pulse and done=0.
  - A load is misaligned when LW has addr_lo!=0, or LH/LHU has addr_lo[0]=1.
  - Byte lanes are little-endian. A byte is taken from bits [8*lo+7:8*lo]; a halfword from bits [16*lo[1]+15:16*lo[1]].
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - mem_rvalid=1 on the same cycle as entry into WAIT_MEM is not possible; mem_rvalid is sampled only while in WAIT_MEM.
- WRITE (exactly one cycle):
  - regwrite=1 unless the destination is 0. A destination of 0 gives regwrite=0 while Waddr and Wdata still carry the values.
  - done=1.
  - Next state is IDLE.
- Outputs are registered.
  - Waddr and Wdata hold their last values outside WRITE.
  - regwrite and done are 0 outside WRITE.
- Latency, handshake to regwrite:
  - Non-load: 1 cycle.
  - Load: 1 cycle after the mem_rvalid edge.
- Back-to-back requests: req_ready returns on the cycle after WRITE. Maximum throughput is 1 request per 2 cycles (non-load).
- The destination is req_waddr, except LINK with req_link_ra=1, which uses LINK_REG.

Decomposition:
- Shared package holds:
  - SRC_ALU/SRC_MEM/SRC_LINK/SRC_LUI encodings.
  - LD_LW/LD_LH/LD_LHU/LD_LB/LD_LBU encodings.
  - State encodings IDLE/WAIT_MEM/WRITE.
- One combinational sub-module, load_align:
  - Inputs: ldtype, addr_lo, rdata.
  - Outputs: data, misalign.
  - Reused later by the pipelined core.

Test Plan:
- ALU request, waddr=5, alu=0x1234_5678 -> next cycle regwrite=1, Waddr=5, Wdata=0x12345678, done=1; the cycle after, req_ready=1.
- LINK with link_ra=1, pc=0x0000_3000 -> Waddr=31, Wdata=0x0000_3008; LUI imm=0xABCD, waddr=8 -> Wdata=0xABCD_0000.
- LB with addr_lo=2, mem_rdata=0x1280_FF34 after 3 wait cycles -> Wdata=0xFFFF_FF80.
  - LBU with the same inputs -> Wdata=0x0000_0080.
  - LH with the same inputs -> Wdata=0x0000_1280.
  - Each writes 1 cycle after mem_rvalid.
- LW with addr_lo=1 -> align_err pulse on the mem_rvalid edge, regwrite=0, done=0, returns to IDLE.
- waddr=0, ALU=0xFFFF_FFFF -> done=1, regwrite=0.
- Reset asserted in WAIT_MEM, followed later by mem_rvalid -> no regwrite or done, all outputs 0 immediately, busy=0.

Source files
------------

// File: rtl/grf_wb_pkg.sv
// Shared encodings for the register-file writeback front end and the load aligner.
package grf_wb_pkg;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_MEM  = 2'b01;
    localparam logic [1:0] SRC_LINK = 2'b10;
    localparam logic [1:0] SRC_LUI  = 2'b11;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_e;

endpackage

// File: rtl/grf_wb_unit_load_align.sv
// Little-endian byte/halfword extraction and extension for loads; flags misaligned or illegal types.
module load_align
    import grf_wb_pkg::*;
(
    input  logic [2:0]  ldtype,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data     = 32'h0;
        misalign = 1'b0;
        case (ldtype)
            LD_LW: begin
                data     = rdata;
                misalign = (addr_lo != 2'b00);
            end
            LD_LH: begin
                data     = {{16{half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            LD_LHU: begin
                data     = {16'h0, half_sel};
                misalign = addr_lo[0];
            end
            LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: data = {24'h0, byte_sel};
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/grf_wb_unit.sv
// Register-file write port sequencer: one writeback per request from ALU, memory, link or LUI.
//   state    | meaning
//   IDLE     | ready for a request
//   WAIT_MEM | load captured, waiting for mem_rvalid
//   WRITE    | write port driven for one cycle, done pulses
module grf_wb_unit
    import grf_wb_pkg::*;
#(
    parameter int unsigned LINK_OFFSET = 8,
    parameter int unsigned LINK_REG    = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_waddr,
    input  logic [1:0]  req_src,
    input  logic        req_link_ra,
    input  logic [31:0] req_alu,
    input  logic [31:0] req_pc,
    input  logic [15:0] req_imm,
    input  logic [2:0]  req_ldtype,
    input  logic [1:0]  req_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  Waddr,
    output logic        regwrite,
    output logic [31:0] Wdata,
    output logic        done,
    output logic        align_err,
    output logic        busy
);

    localparam logic [4:0]  LINK_DEST = 5'(LINK_REG);
    localparam logic [31:0] LINK_ADD  = 32'(LINK_OFFSET);

    state_e      state_q, state_d;
    logic [4:0]  dest_q, dest_d;
    logic [2:0]  ldtype_q, ldtype_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        regwrite_q, regwrite_d;
    logic        done_q, done_d;
    logic        align_err_q, align_err_d;

    logic [4:0]  req_dest;
    logic [31:0] req_result;
    logic [31:0] ld_data;
    logic        ld_misalign;

    load_align u_load_align (
        .ldtype   (ldtype_q),
        .addr_lo  (addr_lo_q),
        .rdata    (mem_rdata),
        .data     (ld_data),
        .misalign (ld_misalign)
    );

    always_comb begin
        req_dest = (req_src == SRC_LINK && req_link_ra) ? LINK_DEST : req_waddr;
        case (req_src)
            SRC_LINK: req_result = req_pc + LINK_ADD;
            SRC_LUI:  req_result = {req_imm, 16'h0};
            default:  req_result = req_alu;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        ldtype_d    = ldtype_q;
        addr_lo_d   = addr_lo_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        regwrite_d  = 1'b0;
        done_d      = 1'b0;
        align_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    dest_d    = req_dest;
                    ldtype_d  = req_ldtype;
                    addr_lo_d = req_addr_lo;
                    if (req_src == SRC_MEM) begin
                        state_d = WAIT_MEM;
                    end else begin
                        state_d    = WRITE;
                        waddr_d    = req_dest;
                        wdata_d    = req_result;
                        regwrite_d = (req_dest != 5'd0);
                        done_d     = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    if (ld_misalign) begin
                        state_d     = IDLE;
                        align_err_d = 1'b1;
                    end else begin
                        state_d    = WRITE;
                        waddr_d    = dest_q;
                        wdata_d    = ld_data;
                        regwrite_d = (dest_q != 5'd0);
                        done_d     = 1'b1;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dest_q      <= 5'd0;
            ldtype_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            waddr_q     <= 5'd0;
            wdata_q     <= 32'h0;
            regwrite_q  <= 1'b0;
            done_q      <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            ldtype_q    <= ldtype_d;
            addr_lo_q   <= addr_lo_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            regwrite_q  <= regwrite_d;
            done_q      <= done_d;
            align_err_q <= align_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign Waddr     = waddr_q;
    assign Wdata     = wdata_q;
    assign regwrite  = regwrite_q;
    assign done      = done_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_grf_wb_unit.sv
// Directed-vector bench for grf_wb_unit with immediate-assertion checks.
module tb_grf_wb_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_waddr;
    logic [1:0]  req_src;
    logic        req_link_ra;
    logic [31:0] req_alu;
    logic [31:0] req_pc;
    logic [15:0] req_imm;
    logic [2:0]  req_ldtype;
    logic [1:0]  req_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  Waddr;
    logic        regwrite;
    logic [31:0] Wdata;
    logic        done;
    logic        align_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    grf_wb_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_waddr   (req_waddr),
        .req_src     (req_src),
        .req_link_ra (req_link_ra),
        .req_alu     (req_alu),
        .req_pc      (req_pc),
        .req_imm     (req_imm),
        .req_ldtype  (req_ldtype),
        .req_addr_lo (req_addr_lo),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .Waddr       (Waddr),
        .regwrite    (regwrite),
        .Wdata       (Wdata),
        .done        (done),
        .align_err   (align_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] lo,
                           input logic [31:0] rd, input logic exp_err, input logic [31:0] exp_data);
        req_valid   = 1'b1;
        req_src     = 2'b01;
        req_waddr   = 5'd10;
        req_ldtype  = lt;
        req_addr_lo = lo;
        req_alu     = 32'hDEAD_BEEF;
        step();
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_wait_ready"}, 32'(req_ready), 32'd0);
        // stray request during the wait must be ignored
        req_src = 2'b00;
        repeat (3) begin
            step();
            chk({tag, "_wait_done"}, 32'(done), 32'd0);
        end
        req_valid  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk({tag, "_align_err"}, 32'(align_err), 32'(exp_err));
        chk({tag, "_done"}, 32'(done), 32'(!exp_err));
        chk({tag, "_regwrite"}, 32'(regwrite), 32'(!exp_err));
        if (!exp_err) begin
            chk({tag, "_Wdata"}, Wdata, exp_data);
            chk({tag, "_Waddr"}, 32'(Waddr), 32'd10);
        end else begin
            chk({tag, "_err_ready"}, 32'(req_ready), 32'd1);
        end
        step();
        chk({tag, "_after_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_after_err"}, 32'(align_err), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_waddr   = 5'd0;
        req_src     = 2'b00;
        req_link_ra = 1'b0;
        req_alu     = 32'h0;
        req_pc      = 32'h0;
        req_imm     = 16'h0;
        req_ldtype  = 3'd0;
        req_addr_lo = 2'd0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        #1;
        chk("rst_Waddr", 32'(Waddr), 32'd0);
        chk("rst_Wdata", Wdata, 32'h0);
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_align_err", 32'(align_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        step();
        step();
        reset = 1'b0;
        step();

        // ALU
        req_valid = 1'b1; req_src = 2'b00; req_waddr = 5'd5; req_alu = 32'h1234_5678;
        step();
        req_valid = 1'b0;
        chk("alu_regwrite", 32'(regwrite), 32'd1);
        chk("alu_Waddr", 32'(Waddr), 32'd5);
        chk("alu_Wdata", Wdata, 32'h1234_5678);
        chk("alu_done", 32'(done), 32'd1);
        chk("alu_ready_in_write", 32'(req_ready), 32'd0);
        step();
        chk("alu_ready_after", 32'(req_ready), 32'd1);
        chk("alu_regwrite_after", 32'(regwrite), 32'd0);
        chk("alu_done_after", 32'(done), 32'd0);
        chk("alu_Wdata_hold", Wdata, 32'h1234_5678);
        chk("alu_Waddr_hold", 32'(Waddr), 32'd5);

        // LINK with return-address override
        req_valid = 1'b1; req_src = 2'b10; req_link_ra = 1'b1; req_waddr = 5'd3; req_pc = 32'h0000_3000;
        step();
        req_valid = 1'b0; req_link_ra = 1'b0;
        chk("link_Waddr", 32'(Waddr), 32'd31);
        chk("link_Wdata", Wdata, 32'h0000_3008);
        chk("link_regwrite", 32'(regwrite), 32'd1);
        step();

        // LINK without override keeps req_waddr
        req_valid = 1'b1; req_src = 2'b10; req_waddr = 5'd4; req_pc = 32'hFFFF_FFFC;
        step();
        req_valid = 1'b0;
        chk("link_noRA_Waddr", 32'(Waddr), 32'd4);
        chk("link_wrap_Wdata", Wdata, 32'h0000_0004);
        step();

        // LUI
        req_valid = 1'b1; req_src = 2'b11; req_waddr = 5'd8; req_imm = 16'hABCD;
        step();
        req_valid = 1'b0;
        chk("lui_Waddr", 32'(Waddr), 32'd8);
        chk("lui_Wdata", Wdata, 32'hABCD_0000);
        step();

        // Loads
        do_load("lb",   3'b011, 2'd2, 32'h1280_FF34, 1'b0, 32'hFFFF_FF80);
        do_load("lbu",  3'b100, 2'd2, 32'h1280_FF34, 1'b0, 32'h0000_0080);
        do_load("lh",   3'b001, 2'd2, 32'h1280_FF34, 1'b0, 32'h0000_1280);
        do_load("lh0",  3'b001, 2'd0, 32'h1280_FF34, 1'b0, 32'hFFFF_FF34);
        do_load("lhu0", 3'b010, 2'd0, 32'h1280_FF34, 1'b0, 32'h0000_FF34);
        do_load("lb3",  3'b011, 2'd3, 32'h7F00_0000, 1'b0, 32'h0000_007F);
        do_load("lw",   3'b000, 2'd0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D);
        do_load("lw_mis",  3'b000, 2'd1, 32'h1111_2222, 1'b1, 32'h0);
        do_load("lhu_mis", 3'b010, 2'd3, 32'h1111_2222, 1'b1, 32'h0);
        do_load("illegal", 3'b101, 2'd0, 32'h1111_2222, 1'b1, 32'h0);
        chk("err_Wdata_hold", Wdata, 32'hCAFE_F00D);

        // Destination zero
        req_valid = 1'b1; req_src = 2'b00; req_waddr = 5'd0; req_alu = 32'hFFFF_FFFF;
        step();
        req_valid = 1'b0;
        chk("r0_done", 32'(done), 32'd1);
        chk("r0_regwrite", 32'(regwrite), 32'd0);
        chk("r0_Waddr", 32'(Waddr), 32'd0);
        chk("r0_Wdata", Wdata, 32'hFFFF_FFFF);
        step();

        // Reset while waiting for memory
        req_valid = 1'b1; req_src = 2'b01; req_waddr = 5'd12; req_ldtype = 3'b000; req_addr_lo = 2'd0;
        step();
        req_valid = 1'b0;
        step();
        chk("rstmid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_Wdata", Wdata, 32'h0);
        chk("rstmid_Waddr", 32'(Waddr), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_regwrite", 32'(regwrite), 32'd0);
        step();
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        chk("rstmid_late_regwrite", 32'(regwrite), 32'd0);
        chk("rstmid_late_done", 32'(done), 32'd0);
        chk("rstmid_late_busy", 32'(busy), 32'd0);
        chk("rstmid_late_Wdata", Wdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
